// File: rtl/us_seq_pkg.sv
// Shared types and helpers for the ultrasonic burst sequencer.
package us_seq_pkg;

  typedef enum logic [2:0] {S_OFF, S_IDLE, S_TX, S_BLANK, S_RX} state_t;

  typedef enum logic [2:0] {
    CMD_NONE, CMD_OFF, CMD_ON, CMD_SEND, CMD_RECV, CMD_INC, CMD_DEC
  } cmd_t;

  // Collapse the command flags into one command: off > on > send > receive > increase > decrease.
  function automatic cmd_t decode_cmd(input logic valid, input logic off, input logic on,
                                      input logic send, input logic recv, input logic inc,
                                      input logic dec);
    if (!valid) return CMD_NONE;
    if (off)    return CMD_OFF;
    if (on)     return CMD_ON;
    if (send)   return CMD_SEND;
    if (recv)   return CMD_RECV;
    if (inc)    return CMD_INC;
    if (dec)    return CMD_DEC;
    return CMD_NONE;
  endfunction

  // a + b clamped to max.
  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned max);
    logic [32:0] sum;
    sum = 33'(a) + 33'(b);
    return (sum > 33'(max)) ? max : 32'(sum);
  endfunction

  // a - b clamped to 0.
  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (a < b) ? 32'd0 : a - b;
  endfunction

endpackage

// File: rtl/us_burst_sequencer_if.sv
// Decoded command bus from the command decoder into the sequencer.
interface us_burst_sequencer_if #(
  parameter int unsigned AMOUNT_WIDTH = 8
);
  logic                    cmd_valid;
  logic                    cmd_on;
  logic                    cmd_off;
  logic                    cmd_increase;
  logic                    cmd_decrease;
  logic                    cmd_send;
  logic                    cmd_receive;
  logic [AMOUNT_WIDTH-1:0] cmd_amount;

  modport master (
    output cmd_valid, cmd_on, cmd_off, cmd_increase, cmd_decrease,
           cmd_send, cmd_receive, cmd_amount
  );

  modport slave (
    input cmd_valid, cmd_on, cmd_off, cmd_increase, cmd_decrease,
          cmd_send, cmd_receive, cmd_amount
  );
endinterface

// File: rtl/us_pulse_gen.sv
// TX burst generator: PULSES periods of HALF_PERIOD high / HALF_PERIOD low.
// tx_pulse rises on the same edge that samples start; done_c flags the last burst cycle.
module us_pulse_gen #(
  parameter int unsigned PULSES      = 8,
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic tx_pulse,
  output logic done_c
);
  localparam int unsigned HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int unsigned PW = (PULSES > 1) ? $clog2(PULSES) : 1;
  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSES - 1);

  logic          active_q;
  logic [HW-1:0] half_q;
  logic [PW-1:0] pulse_q;

  // Final cycle of the low half of the final pulse.
  assign done_c = active_q && !tx_pulse && (half_q == HALF_LAST) && (pulse_q == PULSE_LAST);

  // Half-period and pulse counters; abort and reset clear the drive immediately.
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      active_q <= 1'b0;
      tx_pulse <= 1'b0;
      half_q   <= '0;
      pulse_q  <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      tx_pulse <= 1'b1;
      half_q   <= '0;
      pulse_q  <= '0;
    end else if (active_q) begin
      if (half_q == HALF_LAST) begin
        half_q <= '0;
        if (tx_pulse) begin
          tx_pulse <= 1'b0;
        end else if (pulse_q == PULSE_LAST) begin
          active_q <= 1'b0;
        end else begin
          pulse_q  <= pulse_q + PW'(1);
          tx_pulse <= 1'b1;
        end
      end else begin
        half_q <= half_q + HW'(1);
      end
    end
  end
endmodule

// File: rtl/us_burst_sequencer.sv
// Ultrasonic burst sequencer: DAC level, TX burst, blanking, RX echo window.
// Optional feature macro: US_SEQ_RETRY_EN (retry timed-out sends with a stronger drive).
module us_burst_sequencer
  import us_seq_pkg::*;
#(
  parameter int unsigned AMOUNT_WIDTH = 8,
  parameter int unsigned TIME_WIDTH   = 16,
  parameter int unsigned PULSES       = 8,
  parameter int unsigned HALF_PERIOD  = 2,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned RX_TIMEOUT   = 200,
  parameter int unsigned MAX_RETRY    = 2,
  parameter int unsigned RETRY_STEP   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  us_burst_sequencer_if.slave     cmd_if,
  output logic [AMOUNT_WIDTH-1:0] dac_level,
  output logic                    dac_load,
  output logic                    tx_pulse,
  output logic                    rx_enable,
  input  logic                    echo_detect,
  output logic                    echo_valid,
  output logic [TIME_WIDTH-1:0]   echo_time,
  output logic                    timeout,
  output logic                    cmd_drop,
  output logic                    busy
);
  localparam int unsigned         DAC_MAX    = 2**AMOUNT_WIDTH - 1;
  localparam logic [TIME_WIDTH-1:0] BLANK_LAST = TIME_WIDTH'(BLANK_CYCLES - 1);
  localparam logic [TIME_WIDTH-1:0] RX_LAST    = TIME_WIDTH'(RX_TIMEOUT - 1);
  localparam state_t              TX_EXIT    = (BLANK_CYCLES == 0) ? S_RX : S_BLANK;

  cmd_t                    cmd_c;
  state_t                  state_q, state_d;
  logic [AMOUNT_WIDTH-1:0] amount_c, dac_d;
  logic [TIME_WIDTH-1:0]   timer_q, timer_d, echo_time_d;
  logic                    dac_load_d, echo_valid_d, timeout_d, cmd_drop_d;
  logic                    start_c, abort_c, done_c;

`ifdef US_SEQ_RETRY_EN
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_q, retry_d;
  logic          from_send_q, from_send_d;
`endif

  assign amount_c = AMOUNT_WIDTH'(cmd_if.cmd_amount);
  assign cmd_c    = decode_cmd(cmd_if.cmd_valid, cmd_if.cmd_off, cmd_if.cmd_on, cmd_if.cmd_send,
                               cmd_if.cmd_receive, cmd_if.cmd_increase, cmd_if.cmd_decrease);

  us_pulse_gen #(
    .PULSES      (PULSES),
    .HALF_PERIOD (HALF_PERIOD)
  ) u_pulse_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_c),
    .abort    (abort_c),
    .tx_pulse (tx_pulse),
    .done_c   (done_c)
  );

  // Next state, next DAC level, timer and one-cycle event pulses.
  always_comb begin
    state_d      = state_q;
    dac_d        = dac_level;
    dac_load_d   = 1'b0;
    echo_valid_d = 1'b0;
    echo_time_d  = echo_time;
    timeout_d    = 1'b0;
    cmd_drop_d   = 1'b0;
    timer_d      = timer_q;
    start_c      = 1'b0;
    abort_c      = 1'b0;
`ifdef US_SEQ_RETRY_EN
    retry_d      = retry_q;
    from_send_d  = from_send_q;
`endif
    case (state_q)
      S_OFF: begin
        case (cmd_c)
          CMD_ON: begin
            state_d    = S_IDLE;
            dac_d      = amount_c;
            dac_load_d = 1'b1;
          end
          CMD_OFF, CMD_NONE: ;
          default: cmd_drop_d = 1'b1;
        endcase
      end
      S_IDLE: begin
        case (cmd_c)
          CMD_OFF: begin
            state_d = S_OFF;
            dac_d   = '0;
          end
          CMD_ON:  dac_d = amount_c;
          CMD_INC: dac_d = AMOUNT_WIDTH'(sat_add(32'(dac_level), 32'(amount_c), DAC_MAX));
          CMD_DEC: dac_d = AMOUNT_WIDTH'(sat_sub(32'(dac_level), 32'(amount_c)));
          CMD_SEND: begin
            state_d = S_TX;
            start_c = 1'b1;
`ifdef US_SEQ_RETRY_EN
            from_send_d = 1'b1;
`endif
          end
          CMD_RECV: begin
            state_d = S_RX;
            timer_d = '0;
`ifdef US_SEQ_RETRY_EN
            from_send_d = 1'b0;
`endif
          end
          default: ;
        endcase
      end
      default: begin
        if (cmd_c == CMD_OFF) begin
          // Abort the measurement; no echo or timeout is reported.
          state_d = S_OFF;
          dac_d   = '0;
          abort_c = 1'b1;
        end else begin
          cmd_drop_d = (cmd_c != CMD_NONE);
          case (state_q)
            S_TX: begin
              if (done_c) begin
                state_d = TX_EXIT;
                timer_d = '0;
              end
            end
            S_BLANK: begin
              if (timer_q == BLANK_LAST) begin
                state_d = S_RX;
                timer_d = '0;
              end else begin
                timer_d = timer_q + TIME_WIDTH'(1);
              end
            end
            S_RX: begin
              if (echo_detect) begin
                echo_valid_d = 1'b1;
                echo_time_d  = timer_q;
                state_d      = S_IDLE;
              end else if (timer_q == RX_LAST) begin
`ifdef US_SEQ_RETRY_EN
                if (from_send_q && (retry_q < RW'(MAX_RETRY))) begin
                  dac_d   = AMOUNT_WIDTH'(sat_add(32'(dac_level), RETRY_STEP, DAC_MAX));
                  retry_d = retry_q + RW'(1);
                  state_d = S_TX;
                  start_c = 1'b1;
                end else begin
                  timeout_d = 1'b1;
                  state_d   = S_IDLE;
                end
`else
                timeout_d = 1'b1;
                state_d   = S_IDLE;
`endif
              end else begin
                timer_d = timer_q + TIME_WIDTH'(1);
              end
            end
            default: ;
          endcase
        end
      end
    endcase
`ifdef US_SEQ_RETRY_EN
    if (state_d == S_IDLE || state_d == S_OFF) retry_d = '0;
`endif
    dac_load_d = dac_load_d | (dac_d != dac_level);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_OFF;
      timer_q    <= '0;
      dac_level  <= '0;
      dac_load   <= 1'b0;
      rx_enable  <= 1'b0;
      echo_valid <= 1'b0;
      echo_time  <= '0;
      timeout    <= 1'b0;
      cmd_drop   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      dac_level  <= dac_d;
      dac_load   <= dac_load_d;
      rx_enable  <= (state_d == S_RX);
      echo_valid <= echo_valid_d;
      echo_time  <= echo_time_d;
      timeout    <= timeout_d;
      cmd_drop   <= cmd_drop_d;
      busy       <= (state_d == S_TX) || (state_d == S_BLANK) || (state_d == S_RX);
    end
  end

`ifdef US_SEQ_RETRY_EN
  // Retry bookkeeping for send-initiated measurements.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retry_q     <= '0;
      from_send_q <= 1'b0;
    end else begin
      retry_q     <= retry_d;
      from_send_q <= from_send_d;
    end
  end
`endif
endmodule

// File: tb/tb_us_burst_sequencer.sv
// Directed bench for us_burst_sequencer (default parameters).
module tb_us_burst_sequencer;
  localparam logic [5:0] F_OFF  = 6'b100000;
  localparam logic [5:0] F_ON   = 6'b010000;
  localparam logic [5:0] F_SEND = 6'b001000;
  localparam logic [5:0] F_RECV = 6'b000100;
  localparam logic [5:0] F_INC  = 6'b000010;
  localparam logic [5:0] F_DEC  = 6'b000001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        echo_detect = 1'b0;
  logic [7:0]  dac_level;
  logic        dac_load, tx_pulse, rx_enable, echo_valid, timeout, cmd_drop, busy;
  logic [15:0] echo_time;

  int total = 0;
  int bad   = 0;

  us_burst_sequencer_if #(.AMOUNT_WIDTH(8)) cmd_bus ();

  us_burst_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_if      (cmd_bus),
    .dac_level   (dac_level),
    .dac_load    (dac_load),
    .tx_pulse    (tx_pulse),
    .rx_enable   (rx_enable),
    .echo_detect (echo_detect),
    .echo_valid  (echo_valid),
    .echo_time   (echo_time),
    .timeout     (timeout),
    .cmd_drop    (cmd_drop),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic valid, input logic [5:0] f, input logic [7:0] amt);
    cmd_bus.cmd_valid    = valid;
    cmd_bus.cmd_off      = f[5];
    cmd_bus.cmd_on       = f[4];
    cmd_bus.cmd_send     = f[3];
    cmd_bus.cmd_receive  = f[2];
    cmd_bus.cmd_increase = f[1];
    cmd_bus.cmd_decrease = f[0];
    cmd_bus.cmd_amount   = amt;
  endtask

  // Present one command for one edge; outputs reflecting it are visible on return.
  task automatic do_cmd(input logic [5:0] f, input logic [7:0] amt);
    set_flags(1'b1, f, amt);
    tick();
    set_flags(1'b0, 6'b0, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int hi, errs, rx_cnt, to_cnt, ld_cnt;
    int exp_bursts, exp_dac, exp_loads;
    set_flags(1'b0, 6'b0, 8'd0);
    tick();
    tick();
    check("rst_dac", dac_level, 0);
    check("rst_busy", busy, 0);
    check("rst_tx", tx_pulse, 0);
    check("rst_rx", rx_enable, 0);
    check("rst_load", dac_load, 0);
    rst_n = 1'b1;
    tick();

    // S_OFF rejects everything but on/off
    do_cmd(F_SEND, 8'd0);
    check("off_send_drop", cmd_drop, 1);
    check("off_send_busy", busy, 0);
    do_cmd(F_ON, 8'd100);
    check("on_dac", dac_level, 100);
    check("on_load", dac_load, 1);
    check("on_drop", cmd_drop, 0);
    tick();
    check("on_load_gone", dac_load, 0);

    // Saturating arithmetic
    do_cmd(F_INC, 8'd200);
    check("inc_sat", dac_level, 255);
    check("inc_load", dac_load, 1);
    do_cmd(F_DEC, 8'd255);
    check("dec_zero", dac_level, 0);
    check("dec_load", dac_load, 1);
    do_cmd(F_DEC, 8'd5);
    check("dec_floor", dac_level, 0);
    check("dec_noload", dac_load, 0);
    do_cmd(F_ON, 8'd100);
    check("on2_dac", dac_level, 100);

    // Burst, blank, echo at RX cycle 37
    do_cmd(F_SEND, 8'd0);
    check("tx_busy", busy, 1);
    hi = 0;
    errs = 0;
    for (int i = 0; i < 32; i++) begin
      if (tx_pulse !== (((i / 2) % 2) == 0)) errs++;
      if (rx_enable !== 1'b0) errs++;
      hi += int'(tx_pulse);
      tick();
    end
    check("tx_high_cycles", hi, 16);
    check("tx_shape_errs", errs, 0);
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      if (tx_pulse !== 1'b0 || rx_enable !== 1'b0 || busy !== 1'b1) errs++;
      tick();
    end
    check("blank_errs", errs, 0);
    check("rx_start", rx_enable, 1);
    for (int i = 0; i < 37; i++) tick();
    echo_detect = 1'b1;
    tick();
    echo_detect = 1'b0;
    check("echo_valid", echo_valid, 1);
    check("echo_time", echo_time, 37);
    check("echo_busy", busy, 0);
    check("echo_rx_off", rx_enable, 0);
    tick();
    check("echo_valid_pulse", echo_valid, 0);
    check("echo_time_held", echo_time, 37);

    // Echo outside S_RX is ignored
    echo_detect = 1'b1;
    tick();
    echo_detect = 1'b0;
    check("idle_echo_ignored", echo_valid, 0);

    // Passive receive, no echo
    do_cmd(F_RECV, 8'd0);
    rx_cnt = 0;
    to_cnt = 0;
    hi = 0;
    for (int i = 0; i < 210; i++) begin
      rx_cnt += int'(rx_enable);
      to_cnt += int'(timeout);
      hi += int'(tx_pulse);
      tick();
    end
    check("recv_rx_cycles", rx_cnt, 200);
    check("recv_timeouts", to_cnt, 1);
    check("recv_no_tx", hi, 0);
    check("recv_idle", busy, 0);

    // Echo on the last window cycle is an echo
    do_cmd(F_RECV, 8'd0);
    for (int i = 0; i < 199; i++) tick();
    echo_detect = 1'b1;
    tick();
    echo_detect = 1'b0;
    check("last_echo_valid", echo_valid, 1);
    check("last_echo_time", echo_time, 199);
    check("last_echo_no_to", timeout, 0);

    // Send with no echo: one burst, or three with retries
`ifdef US_SEQ_RETRY_EN
    exp_bursts = 3;
    exp_dac = 132;
    exp_loads = 2;
`else
    exp_bursts = 1;
    exp_dac = 100;
    exp_loads = 0;
`endif
    do_cmd(F_SEND, 8'd0);
    hi = 0;
    to_cnt = 0;
    ld_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      hi += int'(tx_pulse);
      to_cnt += int'(timeout);
      ld_cnt += int'(dac_load);
      tick();
    end
    check("send_to_tx_high", hi, 16 * exp_bursts);
    check("send_to_timeouts", to_cnt, 1);
    check("send_to_loads", ld_cnt, exp_loads);
    check("send_to_dac", dac_level, exp_dac);
    check("send_to_idle", busy, 0);

    // Commands while busy
    do_cmd(F_ON, 8'd100);
    do_cmd(F_RECV, 8'd0);
    tick();
    tick();
    do_cmd(F_INC, 8'd10);
    check("rx_inc_drop", cmd_drop, 1);
    check("rx_inc_dac", dac_level, 100);
    check("rx_inc_busy", busy, 1);
    check("rx_inc_rx", rx_enable, 1);
    do_cmd(F_OFF, 8'd0);
    check("rx_off_rx", rx_enable, 0);
    check("rx_off_busy", busy, 0);
    check("rx_off_dac", dac_level, 0);
    check("rx_off_load", dac_load, 1);
    check("rx_off_no_to", timeout, 0);

    do_cmd(F_ON, 8'd50);
    do_cmd(F_SEND, 8'd0);
    for (int i = 0; i < 4; i++) tick();
    check("tx_mid_high", tx_pulse, 1);
    do_cmd(F_OFF, 8'd0);
    check("tx_off_tx", tx_pulse, 0);
    check("tx_off_busy", busy, 0);
    check("tx_off_dac", dac_level, 0);
    do_cmd(F_INC, 8'd1);
    check("tx_off_in_off", cmd_drop, 1);
    tick();
    check("tx_off_stays_low", tx_pulse, 0);

    // Reset mid-burst
    do_cmd(F_ON, 8'd80);
    do_cmd(F_SEND, 8'd0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_tx", tx_pulse, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dac", dac_level, 0);
    check("mid_rst_drop", cmd_drop, 0);
    rst_n = 1'b1;
    tick();
    check("mid_rst_tx_held", tx_pulse, 0);
    do_cmd(F_INC, 8'd1);
    check("mid_rst_state_off", cmd_drop, 1);

    // Priority: on beats send and decrease
    do_cmd(F_ON, 8'd60);
    do_cmd(F_ON | F_SEND | F_DEC, 8'd70);
    check("prio_dac", dac_level, 70);
    check("prio_load", dac_load, 1);
    check("prio_busy", busy, 0);
    check("prio_drop", cmd_drop, 0);
    tick();
    check("prio_still_idle", tx_pulse, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
